// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
//
// Purpose
//   UART receiver with 16x oversampling, 3-sample majority vote per bit,
//   false-start rejection, framing/overrun detection and a show-ahead
//   receive FIFO presented through a valid/ready handshake. Sits between the
//   board RX pin and the image loader; absorbs bursts while the loader stalls.
//
// Optional feature
//   UART_RX_PARITY_EN : when defined, frames carry a parity bit after the data
//                       bits (even when PARITY_ODD=0, odd when 1). Frames with
//                       a bad parity bit are dropped with an o_parity_err pulse.
//                       When undefined, o_parity_err is tied low.
//
// Parameters
//   CLK_FREQ    system clock in Hz
//   BAUD        line rate in bit/s
//   DATA_BITS   data bits per frame (5..8), LSB first
//   FIFO_DEPTH  receive FIFO entries (power of two, >= 2)
//   PARITY_ODD  parity sense, only used with UART_RX_PARITY_EN
//
// Ports
//   i_clk          system clock, rising edge
//   i_rst          asynchronous reset, active low
//   i_rx           serial line, idle high, asynchronous to i_clk
//   o_data         FIFO head word, meaningful when o_data_valid=1
//   o_data_valid   FIFO non-empty
//   i_data_ready   consumer takes the head when o_data_valid && i_data_ready
//   o_fifo_count   number of entries held
//   o_frame_err    1-cycle pulse: stop bit sampled low, frame dropped
//   o_overrun      1-cycle pulse: good frame arrived with FIFO full, dropped
//   o_parity_err   1-cycle pulse: parity mismatch, frame dropped
// -----------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter int CLK_FREQ   = 12000000,
    parameter int BAUD       = 9600,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int PARITY_ODD = 0
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic                              i_rx,
    output logic [DATA_BITS-1:0]              o_data,
    output logic                              o_data_valid,
    input  logic                              i_data_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   o_fifo_count,
    output logic                              o_frame_err,
    output logic                              o_overrun,
    output logic                              o_parity_err
);

    // Rounded clocks per oversampling tick.
    localparam int OVS_DIV = (CLK_FREQ + 8 * BAUD) / (16 * BAUD);
    localparam int DIV_W   = (OVS_DIV > 1) ? $clog2(OVS_DIV) : 1;
    localparam int BCNT_W  = $clog2(DATA_BITS);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

    // 2-of-3 majority used for every bit decision.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // High when data bits plus received parity bit disagree with the parity sense.
    function automatic logic parity_bad(input logic [DATA_BITS-1:0] d, input logic p);
        return ((^d) ^ p) != (PARITY_ODD != 0);
    endfunction

    // ---------------------------------------------------------------- registers
    logic                   r_rx_meta;
    logic                   r_rx_sync;
    logic                   r_rx_prev;
    state_t                 r_state;
    logic [DIV_W-1:0]       r_div_cnt;
    logic [3:0]             r_tick_cnt;
    logic [BCNT_W-1:0]      r_bit_cnt;
    logic                   r_s7;
    logic                   r_s8;
    logic [DATA_BITS-1:0]   r_shift;
    logic [DATA_BITS-1:0]   r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       r_wr_ptr;
    logic [PTR_W-1:0]       r_rd_ptr;
    logic [CNT_W-1:0]       r_count;
    logic [DATA_BITS-1:0]   r_data;
    logic                   r_valid;
    logic                   r_frame_err;
    logic                   r_overrun;
    logic                   r_parity_err;

    // ---------------------------------------------------------------- wires
    logic                   w_fall;
    logic                   w_tick;
    logic                   w_mid;
    logic                   w_bit_end;
    logic                   w_maj;
    logic                   w_par_bad;
    state_t                 w_state_nxt;
    logic                   w_push;
    logic                   w_frame_err;
    logic                   w_parity_err;
    logic                   w_shift;
    logic                   w_par_cap;
    logic                   w_pop;
    logic                   w_full;
    logic                   w_wr_en;
    logic                   w_overrun;
    logic [CNT_W-1:0]       w_count_nxt;
    logic [DATA_BITS-1:0]   w_head_nxt;
    logic [PTR_W-1:0]       w_rd_ptr_inc;

    assign w_fall    = r_rx_prev & ~r_rx_sync;
    // Divider sits at zero in IDLE, so the first tick lands on the cycle after the start edge.
    assign w_tick    = (r_state != S_IDLE) && (r_div_cnt == {DIV_W{1'b0}});
    assign w_mid     = w_tick && (r_tick_cnt == 4'd9);
    assign w_bit_end = w_tick && (r_tick_cnt == 4'd15);
    assign w_maj     = maj3(r_s7, r_s8, r_rx_sync);

`ifdef UART_RX_PARITY_EN
    logic r_par_bad;

    // Parity verdict is taken mid parity bit and held until the stop bit decides.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_par_bad <= 1'b0;
        end else if (w_par_cap) begin
            r_par_bad <= parity_bad(r_shift, w_maj);
        end
    end

    assign w_par_bad = r_par_bad;
`else
    logic w_unused_par;

    assign w_unused_par = parity_bad(r_shift, 1'b0) ^ w_par_cap;
    assign w_par_bad    = 1'b0;
`endif

    // Two-flop synchroniser plus one more flop for falling-edge detection.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= i_rx;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    // FSM state register.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state and per-cycle control strobes.
    always_comb begin
        w_state_nxt  = r_state;
        w_push       = 1'b0;
        w_frame_err  = 1'b0;
        w_parity_err = 1'b0;
        w_shift      = 1'b0;
        w_par_cap    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_fall) begin
                    w_state_nxt = S_START;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_START: begin
                // A start bit that reads high mid-bit was a glitch.
                if (w_mid && w_maj) begin
                    w_state_nxt = S_IDLE;
                end else if (w_bit_end) begin
                    w_state_nxt = S_DATA;
                end else begin
                    w_state_nxt = S_START;
                end
            end
            S_DATA: begin
                w_shift = w_mid;
                if (w_bit_end && (r_bit_cnt == BCNT_W'(DATA_BITS - 1))) begin
`ifdef UART_RX_PARITY_EN
                    w_state_nxt = S_PARITY;
`else
                    w_state_nxt = S_STOP;
`endif
                end else begin
                    w_state_nxt = S_DATA;
                end
            end
            S_PARITY: begin
                w_par_cap = w_mid;
                if (w_bit_end) begin
                    w_state_nxt = S_STOP;
                end else begin
                    w_state_nxt = S_PARITY;
                end
            end
            S_STOP: begin
                // Deciding at mid stop bit lets the next start edge be caught in its second half.
                if (w_mid) begin
                    if (!w_maj) begin
                        w_frame_err = 1'b1;
                        w_state_nxt = S_BREAK;
                    end else if (w_par_bad) begin
                        w_parity_err = 1'b1;
                        w_state_nxt  = S_IDLE;
                    end else begin
                        w_push      = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_state_nxt = S_STOP;
                end
            end
            S_BREAK: begin
                // Hold here while the line stays low so a break reports only once.
                if (r_rx_sync) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_BREAK;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Oversampling divider, tick-within-bit and data-bit counters.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_div_cnt  <= {DIV_W{1'b0}};
            r_tick_cnt <= 4'd0;
            r_bit_cnt  <= {BCNT_W{1'b0}};
        end else if (r_state == S_IDLE) begin
            r_div_cnt  <= {DIV_W{1'b0}};
            r_tick_cnt <= 4'd0;
            r_bit_cnt  <= {BCNT_W{1'b0}};
        end else begin
            if (r_div_cnt == DIV_W'(OVS_DIV - 1)) begin
                r_div_cnt <= {DIV_W{1'b0}};
            end else begin
                r_div_cnt <= r_div_cnt + DIV_W'(1);
            end
            if (w_tick) begin
                r_tick_cnt <= r_tick_cnt + 4'd1;
            end
            if (w_bit_end && (r_state == S_DATA)) begin
                r_bit_cnt <= r_bit_cnt + BCNT_W'(1);
            end
        end
    end

    // Captures samples at ticks 7 and 8; tick 9 uses the live synced value.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_s7 <= 1'b1;
            r_s8 <= 1'b1;
        end else if (w_tick && (r_tick_cnt == 4'd7)) begin
            r_s7 <= r_rx_sync;
        end else if (w_tick && (r_tick_cnt == 4'd8)) begin
            r_s8 <= r_rx_sync;
        end
    end

    // Data shift register, LSB arrives first so bits enter at the top.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_shift <= {DATA_BITS{1'b0}};
        end else if (w_shift) begin
            r_shift <= {w_maj, r_shift[DATA_BITS-1:1]};
        end
    end

    // FIFO control: push/pop qualification, next count and next show-ahead head.
    always_comb begin
        w_pop        = r_valid && i_data_ready;
        w_full       = (r_count == CNT_W'(FIFO_DEPTH));
        // A pop in the same cycle frees the slot the push needs.
        w_wr_en      = w_push && (!w_full || w_pop);
        w_overrun    = w_push && w_full && !w_pop;
        w_rd_ptr_inc = r_rd_ptr + PTR_W'(1);
        case ({w_wr_en, w_pop})
            2'b10:   w_count_nxt = r_count + CNT_W'(1);
            2'b01:   w_count_nxt = r_count - CNT_W'(1);
            default: w_count_nxt = r_count;
        endcase
        if (w_count_nxt == {CNT_W{1'b0}}) begin
            w_head_nxt = r_data;
        end else if (r_count == {CNT_W{1'b0}}) begin
            w_head_nxt = r_shift;
        end else if (w_pop) begin
            // With one entry left, the new head is the word being written this cycle.
            if (r_count == CNT_W'(1)) begin
                w_head_nxt = r_shift;
            end else begin
                w_head_nxt = r_mem[w_rd_ptr_inc];
            end
        end else begin
            w_head_nxt = r_data;
        end
    end

    // FIFO storage.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= {DATA_BITS{1'b0}};
            end
        end else if (w_wr_en) begin
            r_mem[r_wr_ptr] <= r_shift;
        end
    end

    // FIFO pointers, count, registered head/valid and error pulses.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_wr_ptr     <= {PTR_W{1'b0}};
            r_rd_ptr     <= {PTR_W{1'b0}};
            r_count      <= {CNT_W{1'b0}};
            r_data       <= {DATA_BITS{1'b0}};
            r_valid      <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_ptr_inc;
            end
            r_count      <= w_count_nxt;
            r_data       <= w_head_nxt;
            r_valid      <= (w_count_nxt != {CNT_W{1'b0}});
            r_frame_err  <= w_frame_err;
            r_overrun    <= w_overrun;
            r_parity_err <= w_parity_err;
        end
    end

    assign o_data       = r_data;
    assign o_data_valid = r_valid;
    assign o_fifo_count = r_count;
    assign o_frame_err  = r_frame_err;
    assign o_overrun    = r_overrun;
    assign o_parity_err = r_parity_err;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_fifo
//
// Directed bench for uart_rx_fifo at 16 clocks per bit, 8 data bits, depth 4.
// Stimulus pushes each word that should be delivered into a queue; a monitor
// on the falling clock edge pops and compares on every accepted handshake and
// counts error-flag cycles, which the stimulus process then checks.
// -----------------------------------------------------------------------------
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx = 1'b1;
    logic       ready = 1'b0;
    logic [7:0] data;
    logic       valid;
    logic [2:0] count;
    logic       fe;
    logic       ov;
    logic       pe;

    int         n_checks = 0;
    int         n_pass = 0;
    int         fe_cnt = 0;
    int         ov_cnt = 0;
    int         pe_cnt = 0;
    int         v_cycles = 0;
    int         exp_pe = 0;
    logic [7:0] exp_q[$];
`ifdef UART_RX_PARITY_EN
    logic       par_flip = 1'b0;
`endif

    uart_rx_fifo #(
        .CLK_FREQ  (16000000),
        .BAUD      (1000000),
        .DATA_BITS (8),
        .FIFO_DEPTH(4),
        .PARITY_ODD(0)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_rx        (rx),
        .o_data      (data),
        .o_data_valid(valid),
        .i_data_ready(ready),
        .o_fifo_count(count),
        .o_frame_err (fe),
        .o_overrun   (ov),
        .o_parity_err(pe)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endfunction

    // Scoreboard monitor: compare each accepted word, count flag cycles.
    always @(negedge clk) begin
        if (rst) begin
            if (valid) v_cycles++;
            if (fe) fe_cnt++;
            if (ov) ov_cnt++;
            if (pe) pe_cnt++;
            if (valid && ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", int'(data), -1);
                end else begin
                    chk("rx_word", int'(data), int'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic v, input logic glitch);
        for (int i = 0; i < 16; i++) begin
            rx = (glitch && i == 8) ? ~v : v;
            step(1);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_v, input int glitch_bit);
        send_bit(1'b0, 1'b0);
        for (int b = 0; b < 8; b++) begin
            send_bit(d[b], glitch_bit == b);
        end
`ifdef UART_RX_PARITY_EN
        send_bit((^d) ^ par_flip, 1'b0);
`endif
        send_bit(stop_v, 1'b0);
        rx = 1'b1;
    endtask

    task automatic wait_drain(input string nm);
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) begin
            step(1);
        end
        chk(nm, exp_q.size(), 0);
    endtask

    initial begin
        // Reset state.
        step(3);
        chk("rst_count", int'(count), 0);
        chk("rst_valid", int'(valid), 0);
        chk("rst_data", int'(data), 0);
        chk("rst_flags", int'({fe, ov, pe}), 0);
        rst = 1'b1;
        step(5);

        // 1: single frame with consumer ready.
        ready = 1'b1;
        v_cycles = 0;
        exp_q.push_back(8'h55);
        send_frame(8'h55, 1'b1, -1);
        step(6);
        wait_drain("t1_drain");
        chk("t1_valid_cycles", v_cycles, 1);
        chk("t1_count", int'(count), 0);
        chk("t1_flags", fe_cnt + ov_cnt + pe_cnt, 0);

        // 2: burst into a stalled consumer, then drain in order.
        ready = 1'b0;
        exp_q.push_back(8'hA5); send_frame(8'hA5, 1'b1, -1);
        exp_q.push_back(8'h3C); send_frame(8'h3C, 1'b1, -1);
        exp_q.push_back(8'hFF); send_frame(8'hFF, 1'b1, -1);
        exp_q.push_back(8'h00); send_frame(8'h00, 1'b1, -1);
        step(4);
        chk("t2_count_full", int'(count), 4);
        chk("t2_head", int'(data), 'hA5);
        chk("t2_valid", int'(valid), 1);
        ready = 1'b1;
        wait_drain("t2_drain");
        step(2);
        chk("t2_count_empty", int'(count), 0);

        // 3: overrun on a full FIFO.
        ready = 1'b0;
        exp_q.push_back(8'hA5); send_frame(8'hA5, 1'b1, -1);
        exp_q.push_back(8'h3C); send_frame(8'h3C, 1'b1, -1);
        exp_q.push_back(8'hFF); send_frame(8'hFF, 1'b1, -1);
        exp_q.push_back(8'h00); send_frame(8'h00, 1'b1, -1);
        send_frame(8'h11, 1'b1, -1);
        step(4);
        chk("t3_overrun_cycles", ov_cnt, 1);
        chk("t3_count", int'(count), 4);
        chk("t3_head", int'(data), 'hA5);
        ready = 1'b1;
        wait_drain("t3_drain");

        // 4: framing error with line held low, then recovery.
        send_frame(8'h4B, 1'b0, -1);
        rx = 1'b0;
        step(40);
        rx = 1'b1;
        step(16);
        chk("t4_frame_err_cycles", fe_cnt, 1);
        chk("t4_count", int'(count), 0);
        exp_q.push_back(8'h4B);
        send_frame(8'h4B, 1'b1, -1);
        step(4);
        wait_drain("t4_drain");
        chk("t4_frame_err_once", fe_cnt, 1);

        // 5: idle-line glitch is rejected; mid-bit glitch is voted out.
        rx = 1'b0;
        step(3);
        rx = 1'b1;
        step(40);
        chk("t5_glitch_count", int'(count), 0);
        chk("t5_glitch_valid_none", int'(valid), 0);
        exp_q.push_back(8'hC3);
        send_frame(8'hC3, 1'b1, 2);
        step(4);
        wait_drain("t5_drain");
        chk("t5_no_frame_err", fe_cnt, 1);

        // 6: reset mid-frame abandons it.
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        rx = 1'b0;
        step(5);
        rst = 1'b0;
        rx = 1'b1;
        step(3);
        chk("t6_rst_count", int'(count), 0);
        chk("t6_rst_valid", int'(valid), 0);
        rst = 1'b1;
        step(20);
        exp_q.push_back(8'h12);
        send_frame(8'h12, 1'b1, -1);
        step(4);
        wait_drain("t6_drain");
`ifdef UART_RX_PARITY_EN
        par_flip = 1'b1;
        send_frame(8'h12, 1'b1, -1);
        par_flip = 1'b0;
        exp_pe = 1;
        step(4);
        chk("t6_par_count", int'(count), 0);
        chk("t6_par_valid", int'(valid), 0);
`endif
        step(4);
        chk("parity_err_cycles", pe_cnt, exp_pe);
        chk("overrun_total", ov_cnt, 1);
        chk("final_queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
